// File: rtl/apb_cmd_master_pkg.sv
// Shared definitions for the APB command master: FSM states, APB phase codes, response status bits.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package apb_cmd_master_pkg;

   // FSM encoding, 3 bits wide so later APB blocks can reuse the same state codes
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_ACCESS   = 3'd2,
      ST_W_SETUP  = 3'd3,
      ST_W_ACCESS = 3'd4,
      ST_RESP     = 3'd5
   } state_t;

   // APB phase as {psel, penable}
   localparam logic [1:0] PH_IDLE   = 2'b00;
   localparam logic [1:0] PH_SETUP  = 2'b10;
   localparam logic [1:0] PH_ACCESS = 2'b11;

   // Bit positions inside the response status word
   localparam int RSP_ERR_BIT     = 0;
   localparam int RSP_TIMEOUT_BIT = 1;
   localparam int RSP_STATUS_W    = 2;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for one APB phase; o_hit flags that this cycle's increment reaches TIMEOUT.
// Latency: count updates one cycle after i_en; o_hit is decoded from the registered count.
// Backpressure: none; TIMEOUT=0 disables o_hit entirely (wait forever).
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_hit
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [CW-1:0] r_cnt;

   // Counter clears at the start of each phase and counts ACCESS cycles without pready
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Holding TIMEOUT-1 means the current waiting cycle is the TIMEOUT-th one
   assign o_hit = (TIMEOUT > 0) && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// APB master running one read, write or masked read-modify-write per accepted command.
// Latency: accept N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid N+3; +1 per wait state, +2 for RMW write.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready, then one IDLE cycle.
module apb_cmd_master
   import apb_cmd_master_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16,
   parameter int RMW_EN  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic              cmd_mask_en,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [DATA_W-1:0] cmd_mask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   state_t                  r_state;
   logic                    r_cmd_ready;
   logic                    r_write;
   logic                    r_rmw;
   logic [DATA_W-1:0]       r_wdata;
   logic [DATA_W-1:0]       r_mask;
   logic [DATA_W-1:0]       r_rd_save;
   logic                    r_psel;
   logic                    r_penable;
   logic                    r_pwrite;
   logic [ADDR_W-1:0]       r_paddr;
   logic [DATA_W-1:0]       r_pwdata;
   logic                    r_rsp_valid;
   logic [DATA_W-1:0]       r_rsp_rdata;
   logic [RSP_STATUS_W-1:0] r_status;

   logic                    w_rmw;
   logic [DATA_W-1:0]       w_merged;
   logic                    w_tmr_clr;
   logic                    w_tmr_en;
   logic                    w_hit;

   // A masked write becomes RMW only when the feature is built in
   assign w_rmw    = cmd_write & cmd_mask_en & (RMW_EN != 0);
   assign w_merged = (prdata & ~r_mask) | (r_wdata & r_mask);

   assign w_tmr_clr = (r_state == ST_SETUP) || (r_state == ST_W_SETUP);
   assign w_tmr_en  = ((r_state == ST_ACCESS) || (r_state == ST_W_ACCESS)) && !pready;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clr   (w_tmr_clr),
      .i_en    (w_tmr_en),
      .o_hit   (w_hit)
   );

   // Transfer FSM with every bus and response output registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b1;
         r_write     <= 1'b0;
         r_rmw       <= 1'b0;
         r_wdata     <= '0;
         r_mask      <= '0;
         r_rd_save   <= '0;
         {r_psel, r_penable} <= PH_IDLE;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_status    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_state     <= ST_SETUP;
                  r_cmd_ready <= 1'b0;
                  r_write     <= cmd_write;
                  r_rmw       <= w_rmw;
                  r_wdata     <= cmd_wdata;
                  r_mask      <= cmd_mask;
                  {r_psel, r_penable} <= PH_SETUP;
                  r_paddr     <= cmd_addr;
                  // RMW starts with its read phase
                  r_pwrite    <= cmd_write & ~w_rmw;
                  r_pwdata    <= (cmd_write & ~w_rmw) ? cmd_wdata : '0;
               end
            end
            ST_SETUP: begin
               r_state <= ST_ACCESS;
               {r_psel, r_penable} <= PH_ACCESS;
            end
            ST_ACCESS: begin
               if (pready) begin
                  if (r_rmw && !pslverr) begin
                     r_state   <= ST_W_SETUP;
                     r_rd_save <= prdata;
                     {r_psel, r_penable} <= PH_SETUP;
                     r_pwrite  <= 1'b1;
                     r_pwdata  <= w_merged;
                  end else begin
                     r_state     <= ST_RESP;
                     {r_psel, r_penable} <= PH_IDLE;
                     r_pwrite    <= 1'b0;
                     r_paddr     <= '0;
                     r_pwdata    <= '0;
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdata <= (r_write && !r_rmw) ? '0 : prdata;
                     r_status[RSP_ERR_BIT] <= pslverr;
                  end
               end else if (w_hit) begin
                  r_state     <= ST_RESP;
                  {r_psel, r_penable} <= PH_IDLE;
                  r_pwrite    <= 1'b0;
                  r_paddr     <= '0;
                  r_pwdata    <= '0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_status[RSP_ERR_BIT]     <= 1'b1;
                  r_status[RSP_TIMEOUT_BIT] <= 1'b1;
               end
            end
            ST_W_SETUP: begin
               r_state <= ST_W_ACCESS;
               {r_psel, r_penable} <= PH_ACCESS;
            end
            ST_W_ACCESS: begin
               if (pready || w_hit) begin
                  r_state     <= ST_RESP;
                  {r_psel, r_penable} <= PH_IDLE;
                  r_pwrite    <= 1'b0;
                  r_paddr     <= '0;
                  r_pwdata    <= '0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_rd_save;
                  r_status[RSP_ERR_BIT]     <= pready ? pslverr : 1'b1;
                  r_status[RSP_TIMEOUT_BIT] <= !pready;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_cmd_ready <= 1'b1;
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_status    <= '0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
               {r_psel, r_penable} <= PH_IDLE;
               r_pwrite    <= 1'b0;
               r_paddr     <= '0;
               r_pwdata    <= '0;
               r_rsp_valid <= 1'b0;
               r_status    <= '0;
            end
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign psel        = r_psel;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite;
   assign paddr       = r_paddr;
   assign pwdata      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_status[RSP_ERR_BIT];
   assign rsp_timeout = r_status[RSP_TIMEOUT_BIT];

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a behavioural APB slave.
// Latency: checks cycle offsets of SETUP/ACCESS/response against the command accept cycle.
// Backpressure: exercises a held response while a new command is offered.
module tb_apb_cmd_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic       cmd_mask_en = 1'b0;
   logic [7:0] cmd_addr = '0;
   logic [7:0] cmd_wdata = '0;
   logic [7:0] cmd_mask = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       rsp_timeout;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata;
   logic [7:0] prdata = '0;
   logic       pready = 1'b0;
   logic       pslverr = 1'b0;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   // slave model controls and storage
   logic [7:0] mem [256];
   int         slv_waits = 0;
   logic       slv_err = 1'b0;
   logic       slv_stall = 1'b0;
   int         wcnt = 0;

   // results of the last run_cmd
   int         res_setup, res_access, res_rsp, res_drop, res_nsetup, res_nacc;
   logic [7:0] res_rdata, res_wpw, res_spaddr;
   logic       res_err, res_tmo, res_spwrite;

   apb_cmd_master #(
      .ADDR_W (8), .DATA_W (8), .TIMEOUT (16), .RMW_EN (1)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
      .cmd_mask_en (cmd_mask_en), .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_mask (cmd_mask),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
      .rsp_err (rsp_err), .rsp_timeout (rsp_timeout),
      .psel (psel), .penable (penable), .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata),
      .prdata (prdata), .pready (pready), .pslverr (pslverr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural APB slave: answers after slv_waits wait states, or never when stalled
   always @(negedge clk) begin
      if (!rst_n || !(psel && penable)) begin
         pready = 1'b0; pslverr = 1'b0; wcnt = 0;
      end else if (slv_stall) begin
         pready = 1'b0;
      end else if (wcnt < slv_waits) begin
         pready = 1'b0; wcnt++;
      end else begin
         pready = 1'b1; pslverr = slv_err;
         if (pwrite) begin
            if (!slv_err) mem[paddr] = pwdata;
            prdata = 8'h00;
         end else begin
            prdata = mem[paddr];
         end
      end
   end

   // Issue one command, trace the bus until the response appears, then consume it
   task automatic run_cmd(input logic w, input logic me, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] m);
      int   t0;
      logic prev;
      res_setup = -1; res_access = -1; res_rsp = -1; res_drop = -1;
      res_nsetup = 0; res_nacc = 0; res_wpw = 8'h00; res_spaddr = 8'h00; res_spwrite = 1'b0;
      res_rdata = 8'h00; res_err = 1'b0; res_tmo = 1'b0;
      @(negedge clk);
      cmd_write = w; cmd_mask_en = me; cmd_addr = a; cmd_wdata = wd; cmd_mask = m;
      cmd_valid = 1'b1; t0 = cyc; prev = 1'b0;
      for (int i = 0; i < 60 && res_rsp < 0; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (psel && !penable) begin
            res_nsetup++;
            if (res_setup < 0) begin res_setup = cyc - t0; res_spaddr = paddr; res_spwrite = pwrite; end
         end
         if (!psel && prev && res_drop < 0) res_drop = cyc - t0;
         if (psel && penable) begin
            res_nacc++;
            if (res_access < 0) res_access = cyc - t0;
            if (pwrite) res_wpw = pwdata;
         end
         if (rsp_valid) begin
            res_rsp = cyc - t0; res_rdata = rsp_rdata; res_err = rsp_err; res_tmo = rsp_timeout;
         end
         prev = psel;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      n_checks++; if ({psel, penable, pwrite} !== 3'b000) begin n_fail++; $display("FAIL reset_apb_ctl: got %b want 000", {psel, penable, pwrite}); end
      n_checks++; if ({paddr, pwdata} !== 16'h0000) begin n_fail++; $display("FAIL reset_apb_bus: got %h want 0000", {paddr, pwdata}); end
      n_checks++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 11'h000) begin n_fail++; $display("FAIL reset_rsp: got %h want 000", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); end
   endtask

   task automatic test_write();
      slv_waits = 0; slv_err = 1'b0; slv_stall = 1'b0; mem[8'h04] = 8'h00;
      run_cmd(1'b1, 1'b0, 8'h04, 8'h5A, 8'h00);
      n_checks++; if (res_setup !== 1) begin n_fail++; $display("FAIL wr_setup_cycle: got %0d want 1", res_setup); end
      n_checks++; if (res_access !== 2) begin n_fail++; $display("FAIL wr_access_cycle: got %0d want 2", res_access); end
      n_checks++; if (res_rsp !== 3) begin n_fail++; $display("FAIL wr_rsp_cycle: got %0d want 3", res_rsp); end
      n_checks++; if ({res_spaddr, res_spwrite} !== {8'h04, 1'b1}) begin n_fail++; $display("FAIL wr_setup_addr: got %h/%b want 04/1", res_spaddr, res_spwrite); end
      n_checks++; if (res_wpw !== 8'h5A) begin n_fail++; $display("FAIL wr_pwdata: got %h want 5a", res_wpw); end
      n_checks++; if (mem[8'h04] !== 8'h5A) begin n_fail++; $display("FAIL wr_slave_mem: got %h want 5a", mem[8'h04]); end
      n_checks++; if ({res_err, res_tmo, res_rdata} !== 10'h000) begin n_fail++; $display("FAIL wr_rsp: got %h want 000", {res_err, res_tmo, res_rdata}); end
   endtask

   task automatic test_read_wait();
      slv_waits = 3; mem[8'h08] = 8'hC3;
      run_cmd(1'b0, 1'b0, 8'h08, 8'h00, 8'h00);
      n_checks++; if (res_rsp !== 6) begin n_fail++; $display("FAIL rd_rsp_cycle: got %0d want 6", res_rsp); end
      n_checks++; if (res_nacc !== 4) begin n_fail++; $display("FAIL rd_access_cycles: got %0d want 4", res_nacc); end
      n_checks++; if (res_rdata !== 8'hC3) begin n_fail++; $display("FAIL rd_rdata: got %h want c3", res_rdata); end
      n_checks++; if ({res_err, res_tmo} !== 2'b00) begin n_fail++; $display("FAIL rd_status: got %b want 00", {res_err, res_tmo}); end
      slv_waits = 0;
   endtask

   task automatic test_rmw();
      mem[8'h10] = 8'hF0;
      run_cmd(1'b1, 1'b1, 8'h10, 8'h0F, 8'h3C);
      n_checks++; if (res_spwrite !== 1'b0) begin n_fail++; $display("FAIL rmw_first_is_read: got pwrite %b want 0", res_spwrite); end
      n_checks++; if (res_nsetup !== 2) begin n_fail++; $display("FAIL rmw_setups: got %0d want 2", res_nsetup); end
      n_checks++; if (res_wpw !== 8'hCC) begin n_fail++; $display("FAIL rmw_pwdata: got %h want cc", res_wpw); end
      n_checks++; if (mem[8'h10] !== 8'hCC) begin n_fail++; $display("FAIL rmw_slave_mem: got %h want cc", mem[8'h10]); end
      n_checks++; if (res_rdata !== 8'hF0) begin n_fail++; $display("FAIL rmw_rdata: got %h want f0", res_rdata); end
      n_checks++; if (res_rsp !== 5) begin n_fail++; $display("FAIL rmw_rsp_cycle: got %0d want 5", res_rsp); end
      n_checks++; if ({res_err, res_tmo} !== 2'b00) begin n_fail++; $display("FAIL rmw_status: got %b want 00", {res_err, res_tmo}); end
   endtask

   task automatic test_rmw_err();
      mem[8'h12] = 8'h55; slv_err = 1'b1;
      run_cmd(1'b1, 1'b1, 8'h12, 8'hAA, 8'hFF);
      slv_err = 1'b0;
      n_checks++; if (res_nsetup !== 1) begin n_fail++; $display("FAIL rmwerr_setups: got %0d want 1", res_nsetup); end
      n_checks++; if ({res_err, res_tmo} !== 2'b10) begin n_fail++; $display("FAIL rmwerr_status: got %b want 10", {res_err, res_tmo}); end
      n_checks++; if (mem[8'h12] !== 8'h55) begin n_fail++; $display("FAIL rmwerr_mem: got %h want 55", mem[8'h12]); end
      n_checks++; if (res_rsp !== 3) begin n_fail++; $display("FAIL rmwerr_rsp_cycle: got %0d want 3", res_rsp); end
   endtask

   task automatic test_timeout();
      slv_stall = 1'b1;
      run_cmd(1'b0, 1'b0, 8'h20, 8'h00, 8'h00);
      slv_stall = 1'b0;
      n_checks++; if (res_nacc !== 16) begin n_fail++; $display("FAIL tmo_access_cycles: got %0d want 16", res_nacc); end
      n_checks++; if (res_drop !== 18) begin n_fail++; $display("FAIL tmo_psel_drop: got %0d want 18", res_drop); end
      n_checks++; if (res_rsp !== 18) begin n_fail++; $display("FAIL tmo_rsp_cycle: got %0d want 18", res_rsp); end
      n_checks++; if ({res_err, res_tmo} !== 2'b11) begin n_fail++; $display("FAIL tmo_status: got %b want 11", {res_err, res_tmo}); end
   endtask

   task automatic test_timeout_edge();
      slv_waits = 15; mem[8'h22] = 8'h3E;
      run_cmd(1'b0, 1'b0, 8'h22, 8'h00, 8'h00);
      slv_waits = 0;
      n_checks++; if (res_rsp !== 18) begin n_fail++; $display("FAIL tmoedge_rsp_cycle: got %0d want 18", res_rsp); end
      n_checks++; if ({res_err, res_tmo} !== 2'b00) begin n_fail++; $display("FAIL tmoedge_status: got %b want 00", {res_err, res_tmo}); end
      n_checks++; if (res_rdata !== 8'h3E) begin n_fail++; $display("FAIL tmoedge_rdata: got %h want 3e", res_rdata); end
   endtask

   task automatic test_backpressure();
      int got;
      mem[8'h30] = 8'h77;
      @(negedge clk);
      cmd_write = 1'b0; cmd_mask_en = 1'b0; cmd_addr = 8'h30; cmd_valid = 1'b1;
      @(negedge clk);
      // offer a conflicting write while the read is in flight
      cmd_write = 1'b1; cmd_wdata = 8'h00;
      got = 0;
      for (int i = 0; i < 20 && got == 0; i++) begin
         @(negedge clk);
         if (rsp_valid) got = 1;
      end
      n_checks++; if (got !== 1) begin n_fail++; $display("FAIL bp_rsp_seen: got %0d want 1", got); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, psel} !== {1'b1, 8'h77, 4'b0000}) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got v=%b d=%h e=%b t=%b rdy=%b psel=%b want v=1 d=77 e=0 t=0 rdy=0 psel=0",
                     i, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, psel);
         end
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, cmd_ready); end
      @(negedge clk);
      n_checks++; if ({mem[8'h30], psel} !== {8'h77, 1'b0}) begin n_fail++; $display("FAIL bp_no_stray_write: got mem=%h psel=%b want 77/0", mem[8'h30], psel); end
   endtask

   task automatic test_reset_mid();
      int got;
      slv_stall = 1'b1;
      @(negedge clk);
      cmd_write = 1'b1; cmd_mask_en = 1'b0; cmd_addr = 8'h40; cmd_wdata = 8'h99; cmd_valid = 1'b1;
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (psel && penable) got = 1;
      end
      n_checks++; if (got !== 1) begin n_fail++; $display("FAIL rstmid_access_seen: got %0d want 1", got); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({psel, penable, pwrite, paddr, pwdata} !== 19'h0) begin n_fail++; $display("FAIL rstmid_apb_zero: got %b %b %b %h %h want all 0", psel, penable, pwrite, paddr, pwdata); end
      @(negedge clk);
      rst_n = 1'b1; slv_stall = 1'b0;
      @(negedge clk);
      n_checks++; if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL rstmid_after_release: got rdy=%b psel=%b v=%b want 1/0/0", cmd_ready, psel, rsp_valid); end
      run_cmd(1'b1, 1'b0, 8'h41, 8'h11, 8'h00);
      n_checks++; if ({res_rsp, mem[8'h41]} !== {32'd3, 8'h11}) begin n_fail++; $display("FAIL rstmid_recover: got rsp_cyc=%0d mem=%h want 3/11", res_rsp, mem[8'h41]); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_write();
      test_read_wait();
      test_rmw();
      test_rmw_err();
      test_timeout();
      test_timeout_edge();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule
